// File: rtl/logic_pkg.sv
// Shared opcode encodings and FSM state type for the sequential logic-slice engine.
package logic_pkg;

    localparam int OPR_W = 3;

    localparam logic [OPR_W-1:0] OPR_AND  = 3'b000;
    localparam logic [OPR_W-1:0] OPR_OR   = 3'b001;
    localparam logic [OPR_W-1:0] OPR_NOR  = 3'b010;
    localparam logic [OPR_W-1:0] OPR_NOT  = 3'b011;
    localparam logic [OPR_W-1:0] OPR_BUF  = 3'b100;
    localparam logic [OPR_W-1:0] OPR_XOR  = 3'b101;
    localparam logic [OPR_W-1:0] OPR_NAND = 3'b110;
    localparam logic [OPR_W-1:0] OPR_XNOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational W-bit logic operation built from per-bit gate primitives.
module logic_slice
    import logic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [OPR_W-1:0] opr,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [W-1:0]     y
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic and_b;
            logic or_b;
            logic xor_b;
            logic bit_y;

            and g_and (and_b, a[gi], b[gi]);
            or  g_or  (or_b,  a[gi], b[gi]);
            xor g_xor (xor_b, a[gi], b[gi]);

            always_comb begin
                case (opr)
                    OPR_AND:  bit_y = and_b;
                    OPR_OR:   bit_y = or_b;
                    OPR_NOR:  bit_y = ~or_b;
                    OPR_NOT:  bit_y = ~a[gi];
                    OPR_BUF:  bit_y = a[gi];
                    OPR_XOR:  bit_y = xor_b;
                    OPR_NAND: bit_y = ~and_b;
                    OPR_XNOR: bit_y = ~xor_b;
                    default:  bit_y = and_b;
                endcase
            end

            assign y[gi] = bit_y;
        end
    endgenerate

endmodule

// File: rtl/logic_slice_engine.sv
// Sequential bitwise logic unit evaluating SLICE_W bits per cycle behind a valid/ready handshake.
// Optional LOGIC_ZERO_FLAG_EN adds a registered ZERO output for an all-zero result.
module logic_slice_engine
    import logic_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [OPR_W-1:0] OPR,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             BUSY
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    output logic             ZERO
`endif
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (WIDTH % SLICE_W != 0) begin : g_bad_slice
            $error("logic_slice_engine: WIDTH must be a multiple of SLICE_W");
        end
    endgenerate

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [OPR_W-1:0]   opr_reg;
    logic [WIDTH-1:0]   y_reg;
    logic               out_valid_reg;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] slice_y;
    logic               last_slice;

    // Select the operand slice addressed by the counter.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (cnt_reg == CNT_W'(s)) begin
                a_slice = a_reg[s*SLICE_W +: SLICE_W];
                b_slice = b_reg[s*SLICE_W +: SLICE_W];
            end
        end
    end

    assign last_slice = (cnt_reg == CNT_W'(NSLICE - 1));

    logic_slice #(.W(SLICE_W)) u_slice (
        .opr (opr_reg),
        .a   (a_slice),
        .b   (b_slice),
        .y   (slice_y)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            opr_reg       <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        opr_reg   <= OPR;
                        y_reg     <= '0;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int s = 0; s < NSLICE; s++) begin
                        if (cnt_reg == CNT_W'(s)) begin
                            y_reg[s*SLICE_W +: SLICE_W] <= slice_y;
                        end
                    end
                    if (last_slice) begin
                        cnt_reg       <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // New requests wait for IDLE even if offered alongside OUT_READY.
                    if (OUT_READY) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef LOGIC_ZERO_FLAG_EN
    logic nonzero_reg;
    logic zero_reg;

    // Running OR over completed slices avoids a full-width compare at the end.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nonzero_reg <= 1'b0;
            zero_reg    <= 1'b0;
        end else if (state_reg == ST_IDLE && IN_VALID) begin
            nonzero_reg <= 1'b0;
            zero_reg    <= 1'b0;
        end else if (state_reg == ST_RUN) begin
            nonzero_reg <= nonzero_reg | (|slice_y);
            if (last_slice) begin
                zero_reg <= ~(nonzero_reg | (|slice_y));
            end
        end
    end

    assign ZERO = zero_reg;
`endif

    assign IN_READY  = (state_reg == ST_IDLE);
    assign BUSY      = (state_reg != ST_IDLE);
    assign OUT_VALID = out_valid_reg;
    assign Y         = y_reg;

endmodule

// File: tb/tb_logic_slice_engine.sv
// Directed self-checking bench for logic_slice_engine (main instance SLICE_W=8, plus 32/16/1 for the latency sweep).
module tb_logic_slice_engine;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  opr;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;

    logic        in_ready, out_valid, busy;
    logic [31:0] y;
    logic        in_ready_32, out_valid_32, busy_32;
    logic [31:0] y_32;
    logic        in_ready_16, out_valid_16, busy_16;
    logic [31:0] y_16;
    logic        in_ready_1, out_valid_1, busy_1;
    logic [31:0] y_1;
`ifdef LOGIC_ZERO_FLAG_EN
    logic        zero, zero_32, zero_16, zero_1;
`endif

    int n_total;
    int n_pass;

    logic_slice_engine #(.WIDTH(32), .SLICE_W(8)) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .OPR(opr),
        .A(a), .B(b), .OUT_VALID(out_valid), .OUT_READY(out_ready), .Y(y), .BUSY(busy)
`ifdef LOGIC_ZERO_FLAG_EN
        , .ZERO(zero)
`endif
    );

    logic_slice_engine #(.WIDTH(32), .SLICE_W(32)) u_dut32 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_32), .OPR(opr),
        .A(a), .B(b), .OUT_VALID(out_valid_32), .OUT_READY(out_ready), .Y(y_32), .BUSY(busy_32)
`ifdef LOGIC_ZERO_FLAG_EN
        , .ZERO(zero_32)
`endif
    );

    logic_slice_engine #(.WIDTH(32), .SLICE_W(16)) u_dut16 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_16), .OPR(opr),
        .A(a), .B(b), .OUT_VALID(out_valid_16), .OUT_READY(out_ready), .Y(y_16), .BUSY(busy_16)
`ifdef LOGIC_ZERO_FLAG_EN
        , .ZERO(zero_16)
`endif
    );

    logic_slice_engine #(.WIDTH(32), .SLICE_W(1)) u_dut1 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_1), .OPR(opr),
        .A(a), .B(b), .OUT_VALID(out_valid_1), .OUT_READY(out_ready), .Y(y_1), .BUSY(busy_1)
`ifdef LOGIC_ZERO_FLAG_EN
        , .ZERO(zero_1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        case (op)
            3'd0: ref_op = av & bv;
            3'd1: ref_op = av | bv;
            3'd2: ref_op = ~(av | bv);
            3'd3: ref_op = ~av;
            3'd4: ref_op = av;
            3'd5: ref_op = av ^ bv;
            3'd6: ref_op = ~(av & bv);
            default: ref_op = ~(av ^ bv);
        endcase
    endfunction

    // Wait (bounded) for the main instance to raise OUT_VALID; returns cycles waited.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp);
        int lat;
        in_valid = 1'b1; opr = op; a = av; b = bv;
        step;
        in_valid = 1'b0;
        wait_done(lat);
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " y"}, y, exp);
        $display("op=%0d a=%h b=%h y=%h latency=%0d", op, av, bv, y, lat);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int lat32, lat16, lat1;
        logic [31:0] y_hold;

        n_total = 0; n_pass = 0;
        rst = 1'b1; in_valid = 1'b0; opr = '0; a = '0; b = '0; out_ready = 1'b0;
        step; step;
        rst = 1'b0;
        step;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset y", y, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
`ifdef LOGIC_ZERO_FLAG_EN
        check("reset zero", 32'(zero), 32'd0);
`endif

        // Basic ops with hand-computed results
        run_op("and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        run_op("nor", 3'b010, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
        run_op("xor", 3'b101, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h2152_4110);

        // Opcode sweep against the reference model
        for (int op = 0; op < 8; op++) begin
            run_op($sformatf("sweep op%0d", op), 3'(op), 32'h1234_5678, 32'h0FF0_A5C3,
                   ref_op(3'(op), 32'h1234_5678, 32'h0FF0_A5C3));
        end

        // Backpressure: hold DONE with a new request pending
        in_valid = 1'b1; opr = 3'b000; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
        step;
        in_valid = 1'b1; opr = 3'b001; a = 32'h1111_1111; b = 32'h0F0F_0F0F;
        wait_done(lat);
        check("bp latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            check("bp y stable", y, 32'hF000_F000);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
            step;
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp no accept in done", 32'(in_ready), 32'd1);
        step;
        in_valid = 1'b0;
        check("bp accept in idle", 32'(busy), 32'd1);
        wait_done(lat);
        check("bp second y", y, 32'h1F1F_1F1F);
        $display("op=1 a=11111111 b=0f0f0f0f y=%h latency=%0d", y, lat + 1);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;

        // Async reset mid-RUN with two slices done
        in_valid = 1'b1; opr = 3'b001; a = 32'hFFFF_FFFF; b = 32'h0;
        step;
        in_valid = 1'b0;
        step; step;
        check("partial y", y, 32'h0000_FFFF);
        #2 rst = 1'b1;
        #1;
        check("async rst y", y, 32'd0);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        run_op("after rst", 3'b111, 32'hA5A5_0000, 32'h5A5A_FFFF, 32'h0000_0000);

        // Slice-width sweep with operands changed mid-RUN
        rst = 1'b1;
        step;
        rst = 1'b0;
        step;
        in_valid = 1'b1; opr = 3'b000; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
        step;
        in_valid = 1'b0; opr = 3'b001; a = 32'h1357_9BDF; b = 32'hFFFF_0000;
        lat = 0; lat32 = 0; lat16 = 0; lat1 = 0;
        for (int n = 1; n <= 40; n++) begin
            step;
            if (out_valid    && lat   == 0) lat   = n;
            if (out_valid_32 && lat32 == 0) lat32 = n;
            if (out_valid_16 && lat16 == 0) lat16 = n;
            if (out_valid_1  && lat1  == 0) lat1  = n;
        end
        check("sw8 latency", 32'(lat), 32'd4);
        check("sw32 latency", 32'(lat32), 32'd1);
        check("sw16 latency", 32'(lat16), 32'd2);
        check("sw1 latency", 32'(lat1), 32'd32);
        check("sw8 y", y, 32'hF000_F000);
        check("sw32 y", y_32, 32'hF000_F000);
        check("sw16 y", y_16, 32'hF000_F000);
        check("sw1 y", y_1, 32'hF000_F000);
        $display("sweep latencies 8:%0d 32:%0d 16:%0d 1:%0d y1=%h", lat, lat32, lat16, lat1, y_1);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        y_hold = y_32;
        check("sw32 drop", 32'(out_valid_32), 32'd0);

`ifdef LOGIC_ZERO_FLAG_EN
        run_op("zero and", 3'b000, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000);
        check("zero flag set", 32'(zero), 32'd1);
        run_op("zero or", 3'b001, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
        check("zero flag clear", 32'(zero), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
